// File: rtl/mash111_noise_combiner.sv
// MASH 1-1-1 noise combiner: aligns the cascade carries, cancels the noise and clamps int+sdm.
// Latency: q3/int hit the outputs on the same enabled edge; q2 one edge later; q1 two edges later.
// No backpressure: i_en stalls the whole pipeline, i_clr wipes it.
module mash111_noise_combiner #(
    parameter int P_INT_WIDTH = 8,
    parameter int P_SDM_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic                   i_q1,
    input  logic                   i_q2,
    input  logic                   i_q3,
    input  logic [P_INT_WIDTH-1:0] i_int,
    output logic [P_SDM_WIDTH-1:0] o_sdm,
    output logic [P_INT_WIDTH-1:0] o_div,
    output logic                   o_valid,
    output logic                   o_err
);

    localparam int SW = P_INT_WIDTH + 2;

    logic d1a_q, d1b_q, d2a_q, a2p_q, a3p_q, a3pp_q;
    logic [1:0]             cnt_q, cnt_d;
    logic [P_SDM_WIDTH-1:0] sdm_q, sdm_d;
    logic [P_INT_WIDTH-1:0] div_q, div_d;
    logic                   err_q, err_d;

    logic              a1, a2, a3;
    logic signed [4:0] y;
    logic signed [SW-1:0] s;
    logic              under, over;

    assign a1 = d1b_q;
    assign a2 = d2a_q;
    assign a3 = i_q3;

    always_comb begin
        y = $signed({4'b0000, a1}) + $signed({4'b0000, a2}) - $signed({4'b0000, a2p_q})
          + $signed({4'b0000, a3}) - $signed({3'b000, a3p_q, 1'b0})
          + $signed({4'b0000, a3pp_q});
        s     = $signed({2'b00, i_int}) + SW'(y);
        under = s[SW-1];
        // Positive sums above the int range spill into bit P_INT_WIDTH only.
        over  = !s[SW-1] && (s[SW-2:P_INT_WIDTH] != '0);

        sdm_d = P_SDM_WIDTH'(y);
        err_d = err_q | under | over;
        if (under) begin
            div_d = '0;
        end else if (over) begin
            div_d = '1;
        end else begin
            div_d = s[P_INT_WIDTH-1:0];
        end
        cnt_d = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            d1a_q  <= 1'b0;
            d1b_q  <= 1'b0;
            d2a_q  <= 1'b0;
            a2p_q  <= 1'b0;
            a3p_q  <= 1'b0;
            a3pp_q <= 1'b0;
            cnt_q  <= 2'd0;
            sdm_q  <= '0;
            div_q  <= '0;
            err_q  <= 1'b0;
        end else if (i_clr) begin
            d1a_q  <= 1'b0;
            d1b_q  <= 1'b0;
            d2a_q  <= 1'b0;
            a2p_q  <= 1'b0;
            a3p_q  <= 1'b0;
            a3pp_q <= 1'b0;
            cnt_q  <= 2'd0;
            sdm_q  <= '0;
            div_q  <= '0;
            err_q  <= 1'b0;
        end else if (i_en) begin
            d1a_q  <= i_q1;
            d1b_q  <= d1a_q;
            d2a_q  <= i_q2;
            a2p_q  <= a2;
            a3p_q  <= a3;
            a3pp_q <= a3p_q;
            cnt_q  <= cnt_d;
            sdm_q  <= sdm_d;
            div_q  <= div_d;
            err_q  <= err_d;
        end
    end

    assign o_sdm   = sdm_q;
    assign o_div   = div_q;
    assign o_valid = (cnt_q == 2'd3);
    assign o_err   = err_q;

endmodule

// File: tb/tb_mash111_noise_combiner.sv
// Directed bench for mash111_noise_combiner with hand-computed expectations.
module tb_mash111_noise_combiner;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_en;
    logic       i_clr;
    logic       i_q1, i_q2, i_q3;
    logic [7:0] i_int;
    logic [3:0] o_sdm;
    logic [7:0] o_div;
    logic       o_valid;
    logic       o_err;

    int n_cmp  = 0;
    int n_fail = 0;

    mash111_noise_combiner #(.P_INT_WIDTH(8), .P_SDM_WIDTH(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_clr   (i_clr),
        .i_q1    (i_q1),
        .i_q2    (i_q2),
        .i_q3    (i_q3),
        .i_int   (i_int),
        .o_sdm   (o_sdm),
        .o_div   (o_div),
        .o_valid (o_valid),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drv(input logic en, input logic q1, input logic q2, input logic q3,
                       input logic [7:0] iv);
        i_en = en; i_q1 = q1; i_q2 = q2; i_q3 = q3; i_int = iv;
    endtask

    task automatic do_clr();
        i_clr = 1'b1; i_en = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("clr_sdm", o_sdm, 4'h0);
        chk("clr_div", o_div, 8'd0);
        chk("clr_valid", o_valid, 1'b0);
        chk("clr_err", o_err, 1'b0);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sdm, input logic [7:0] dv);
        chk({tag, "_sdm"}, o_sdm, sdm);
        chk({tag, "_div"}, o_div, dv);
    endtask

    initial begin
        // 1: reset with enable and all carries high
        i_rst_n = 1'b0; i_clr = 1'b0;
        drv(1'b1, 1'b1, 1'b1, 1'b1, 8'd20);
        tick(); tick();
        chk_out("rst", 4'h0, 8'd0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_err", o_err, 1'b0);
        i_rst_n = 1'b1;
        tick(); chk("fill1_valid", o_valid, 1'b0);
        tick(); chk("fill2_valid", o_valid, 1'b0);
        tick(); chk("fill3_valid", o_valid, 1'b1);
        chk("fill3_err", o_err, 1'b0);

        // 2: constant q1 -> y=+1 once aligned
        do_clr();
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'd10);
        tick(); chk_out("c1", 4'h0, 8'd10);
        tick(); chk_out("c2", 4'h0, 8'd10);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("const", 4'h1, 8'd11);
            chk("const_valid", o_valid, 1'b1);
            chk("const_err", o_err, 1'b0);
        end

        // 3: single q3 pulse -> +1, -2, +1, 0
        do_clr();
        drv(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
        tick(); chk_out("p3_k0", 4'h1, 8'd11);
        i_q3 = 1'b0;
        tick(); chk_out("p3_k1", 4'hE, 8'd8);
        tick(); chk_out("p3_k2", 4'h1, 8'd11);
        tick(); chk_out("p3_k3", 4'h0, 8'd10);

        // 4: staggered pulses line up on one edge
        do_clr();
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'd10);
        tick(); chk_out("skew_k0", 4'h0, 8'd10);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 8'd10);
        tick(); chk_out("skew_k1", 4'h0, 8'd10);
        drv(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
        tick(); chk_out("skew_k2", 4'h3, 8'd13);

        // 5a: y=-3 with int=1 clamps low
        do_clr();
        drv(1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
        tick(); chk_out("lo_e0", 4'h0, 8'd1);
        drv(1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        tick(); chk_out("lo_e1", 4'h2, 8'd3);
        chk("lo_e1_err", o_err, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        tick(); chk_out("lo_e2", 4'hD, 8'd0);
        chk("lo_e2_err", o_err, 1'b1);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 8'd50);
        tick(); tick(); tick();
        chk_out("lo_after", 4'h0, 8'd50);
        chk("lo_sticky", o_err, 1'b1);
        do_clr();

        // 5b: y=+4 with int=FE clamps high
        drv(1'b1, 1'b1, 1'b0, 1'b1, 8'hFE);
        tick(); chk_out("hi_e0", 4'h1, 8'hFF);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 8'hFE);
        tick(); chk_out("hi_e1", 4'hE, 8'hFC);
        chk("hi_e1_err", o_err, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b1, 8'hFE);
        tick(); chk_out("hi_e2", 4'h4, 8'hFF);
        chk("hi_e2_err", o_err, 1'b1);

        // 6: scenario 3 with disabled gaps carrying junk inputs
        do_clr();
        drv(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
        tick(); chk_out("gap_k0", 4'h1, 8'd11);
        drv(1'b0, 1'b1, 1'b1, 1'b1, 8'd99);
        repeat (5) tick();
        chk_out("gap_hold0", 4'h1, 8'd11);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
        tick(); chk_out("gap_k1", 4'hE, 8'd8);
        drv(1'b0, 1'b1, 1'b1, 1'b1, 8'd99);
        repeat (5) tick();
        chk_out("gap_hold1", 4'hE, 8'd8);
        chk("gap_hold1_valid", o_valid, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
        tick(); chk_out("gap_k2", 4'h1, 8'd11);
        chk("gap_k2_valid", o_valid, 1'b1);
        drv(1'b0, 1'b1, 1'b1, 1'b1, 8'd99);
        repeat (5) tick();
        chk_out("gap_hold2", 4'h1, 8'd11);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
        tick(); chk_out("gap_k3", 4'h0, 8'd10);

        // clear beats enable mid-run
        drv(1'b1, 1'b1, 1'b1, 1'b1, 8'd10);
        tick();
        do_clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mash111_noise_combiner.md
Name: mash111_noise_combiner

Overview:
- Downstream stage of the three cascaded EFM accumulators in the MASH 1-1-1 DDSM.
- Takes the per-stage carry (quantize) bits and aligns them for the one-cycle-per-stage pipeline skew of the cascade.
- Applies the MASH noise-cancellation differentiators (1, 1-z^-1, (1-z^-1)^2) to form the signed multi-level modulator output.
- Adds the integer divide word and drives the divider ratio, clamped, with a sticky range-error flag.

Parameters:
P_INT_WIDTH, 8, width of integer divide word i_int and of output o_div (unsigned)
P_SDM_WIDTH, 4, width of signed modulator output o_sdm; must be >=4 (range -3..+4)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  advance enable; all state updates only when 1
i_clr  input  1  synchronous clear of history, fill counter, outputs and error flag
i_q1  input  1  carry bit from EFM stage 1 (earliest stage)
i_q2  input  1  carry bit from EFM stage 2 (one cycle later than stage 1)
i_q3  input  1  carry bit from EFM stage 3 (two cycles later than stage 1)
i_int  input  P_INT_WIDTH  unsigned integer part of divide ratio
o_sdm  output  P_SDM_WIDTH  signed combined modulator value, two's complement
o_div  output  P_INT_WIDTH  registered clamped i_int + o_sdm
o_valid  output  1  high once pipeline history is filled
o_err  output  1  sticky: a clamp event occurred since reset/clear

Behaviour:
- Reset (async, i_rst_n=0):
  - All history registers = 0; fill counter = 0.
  - o_sdm = 0, o_div = 0, o_valid = 0, o_err = 0.
- Priority on each rising edge: i_clr > i_en.
  - i_clr=1: same state as reset, regardless of i_en.
  - i_en=0 and i_clr=0: every register, including outputs, holds.
- Alignment on each enabled edge:
  - q1 passes through two delay regs: d1a <= i_q1, d1b <= d1a.
  - q2 passes through one delay reg: d2a <= i_q2.
  - q3 is not delayed.
  - Aligned terms: a1 = d1b, a2 = d2a, a3 = i_q3.
- Differentiator history on each enabled edge:
  - a2p <= a2.
  - a3p <= a3, a3pp <= a3p.
- Combination, in at least 5-bit signed arithmetic: y = a1 + a2 - a2p + a3 - 2*a3p + a3pp.
  - Range -3..+4; no overflow possible in P_SDM_WIDTH.
  - o_sdm <= y, sign-extended to P_SDM_WIDTH.
- Divide ratio:
  - s = zero-extended i_int + sign-extended y, computed at P_INT_WIDTH+2 bits.
  - s < 0: o_div <= 0, o_err <= 1.
  - s > 2^P_INT_WIDTH-1: o_div <= all ones, o_err <= 1.
  - Otherwise: o_div <= s[P_INT_WIDTH-1:0].
  - o_err is only evaluated on enabled edges; it stays 1 until reset or i_clr.
  - A clamp detected during fill still sets o_err.
- Latency, counted in enabled edges; outputs update on the edge at which the terms are consumed:
  - i_q3 sampled at edge k reaches o_sdm/o_div at edge k.
  - i_q2 reaches them at edge k+1.
  - i_q1 reaches them at edge k+2.
  - i_int sampled at edge k contributes at edge k.
- Fill counter:
  - 2-bit, saturating at 3; increments on enabled edges.
  - o_valid = 1 when the counter is 3, i.e. after the 3rd enabled edge following reset/clear.
  - Outputs are still computed during fill from zeroed history.
- Disabled cycles are invisible: a gap of i_en=0 between enabled edges does not change any result.
- i_q*/i_int are sampled only on enabled edges; values during i_en=0 are ignored.

Test Plan:
1. Reset with i_en=1 held, i_int=8'd20, all q=1 -> while i_rst_n=0: o_sdm=0, o_div=0, o_valid=0, o_err=0; after release, o_valid rises exactly at the 3rd enabled edge.
2. i_int=10, i_q1=1, i_q2=0, i_q3=0 constant, i_en=1 -> after fill, o_sdm=1 and o_div=11 every cycle, o_err=0.
3. Single-cycle i_q3=1 pulse at edge k, other q=0, i_int=10 -> o_sdm = +1, -2, +1 at edges k, k+1, k+2, then 0; o_div = 11, 8, 11, 10.
4. Skew check, i_int=10: i_q1 pulse at edge k, i_q2 pulse at edge k+1, i_q3 pulse at edge k+2 -> o_sdm=3 and o_div=13 at edge k+2.
5. Clamp, i_int=1, extremes:
   - Drive history a1=0, a2=0, a2p=1, a3=0, a3p=1, a3pp=0 -> o_sdm=-3, o_div=0, o_err=1.
   - o_err stays 1 through later in-range values; i_clr drops it to 0 with o_valid=0.
   - i_int=8'hFE with y=+4 (a1=1, a2=1, a2p=0, a3=1, a3p=0, a3pp=1) -> o_div=8'hFF, o_err=1.
6. Enable gaps: repeat scenario 3 with i_en=0 inserted for 5 cycles between each enabled edge -> identical o_sdm/o_div sequence per enabled edge, outputs held during gaps; i_clr=1 with i_en=1 mid-run -> clear wins, all state zero next cycle.
